// File: rtl/axi_result_writer.sv
// axi_result_writer
// Takes one 64-bit result row (eight bytes of C[row][*]) and writes it to the
// result matrix in memory as a single two-beat, 32-bit AXI INCR write burst.
// Only one row is held at a time; the block is ready again only after the
// write response has been collected and done has pulsed.
module axi_result_writer #(
  parameter logic [11:0] BASE_ADDR = 12'd0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_row,
  input  logic [63:0] in_data,

  output logic        busy,
  output logic        done,
  output logic        error,

  output logic [11:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [3:0]  m_axi_awcache,
  output logic        m_axi_awlock,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,

  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,

  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_t;

  state_t      state_q;
  logic [2:0]  row_q;
  logic [63:0] data_q;
  logic        beat_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        wlast_q;
  logic        bready_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;

  // Burst shape is fixed: two 4-byte beats, incrementing, all bytes enabled.
  assign m_axi_awlen   = 8'd1;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = 4'hF;

  // Each row is 8 bytes, so the row index becomes byte offset row*8; the add
  // is 12 bits wide so addresses past the top of the window wrap around.
  assign m_axi_awaddr = BASE_ADDR + {6'd0, row_q, 3'd0};

  // Low word goes out first, high word second; data_q and beat_q only change
  // on a handshake, so the beat on the bus is stable while the slave stalls.
  assign m_axi_wdata = beat_q ? data_q[63:32] : data_q[31:0];

  // Ready is withheld while reset is asserted and comes up as soon as it drops.
  assign in_ready = (state_q == IDLE) && !rst;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_bready  = bready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  // Transaction sequencer: every AXI-facing control output is a register that
  // is set or cleared on the same edge as the state change it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_q     <= 3'd0;
      data_q    <= 64'd0;
      beat_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            row_q     <= in_row;
            data_q    <= in_data;
            beat_q    <= 1'b0;
            error_q   <= 1'b0;
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= 1'b0;
            beat_q    <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (m_axi_wready) begin
            if (!beat_q) begin
              beat_q  <= 1'b1;
              wlast_q <= 1'b1;
            end else begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= RESP;
            end
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            error_q  <= (m_axi_bresp != 2'b00);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          wlast_q   <= 1'b0;
          bready_q  <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_result_writer.md
AXI_RESULT_WRITER -- requirements
Module: axi_result_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'd0, byte address of the C result matrix; row r occupies bytes BASE_ADDR+8r .. +8r+7.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  result row offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a row.
REQ-006 SHALL have port in_row  input  3  row index 0..7.
REQ-007 SHALL have port in_data  input  64  row data; byte k = C[row][k].
REQ-008 SHALL have port busy  output  1  transaction in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-010 SHALL have port error  output  1  last transaction got a non-OKAY response.
REQ-011 SHALL have ports m_axi_awaddr  output  12; m_axi_awlen  output  8; m_axi_awsize  output  3; m_axi_awburst  output  2; m_axi_awcache  output  4; m_axi_awlock  output  1; m_axi_awprot  output  3; m_axi_awvalid  output  1; m_axi_awready  input  1.
REQ-012 SHALL have ports m_axi_wdata  output  32; m_axi_wstrb  output  4; m_axi_wlast  output  1; m_axi_wvalid  output  1; m_axi_wready  input  1.
REQ-013 SHALL have ports m_axi_bresp  input  2; m_axi_bvalid  input  1; m_axi_bready  output  1.

Function
REQ-014 SHALL use FSM states IDLE, ADDR, DATA, RESP, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a row is accepted on in_valid&&in_ready, latching in_row and in_data and moving to ADDR next cycle.
REQ-016 SHALL drive m_axi_awvalid=1 throughout ADDR, with awaddr=BASE_ADDR+(row<<3) modulo 2^12 held stable until the AW handshake.
REQ-017 SHALL tie awlen=8'd1 (2 beats), awsize=3'b010, awburst=2'b01 INCR, awcache=4'b0011, awlock=0, awprot=3'b000.
REQ-018 SHALL leave ADDR for DATA on awvalid&&awready, clearing the beat counter to 0.
REQ-019 SHALL not assert m_axi_wvalid before the AW handshake completes; wvalid=1 throughout DATA.
REQ-020 SHALL drive wdata=in_data[31:0] on beat 0 and in_data[63:32] on beat 1; wstrb=4'hF; wlast=1 only on beat 1.
REQ-021 SHALL hold wdata/wlast stable while wvalid&&!wready; advance beat only on wvalid&&wready; after beat 1 handshake go to RESP.
REQ-022 SHALL drive m_axi_bready=1 only in RESP; on bvalid go to DONE and register error=(bresp!=2'b00).
REQ-023 SHALL pulse done=1 for exactly one cycle in DONE, then return to IDLE; error SHALL hold until the next accepted row clears it.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL ignore in_valid outside IDLE; no input buffering beyond the one latched row.
REQ-026 SHALL take at best 5 cycles accept-to-done with all readies high (ADDR, DATA b0, DATA b1, RESP, DONE); any ready/bvalid stall extends the matching state indefinitely.
REQ-027 SHALL treat an awready arriving one cycle before/after wvalid consideration strictly per REQ-019 (W never leads AW).

Reset
REQ-028 SHALL on rst, immediately and asynchronously, enter IDLE and drive awvalid=0, wvalid=0, wlast=0, bready=0, busy=0, done=0, error=0, in_ready=0 until rst deasserts (then 1), latched row/data/beat=0.
REQ-029 SHALL abandon any in-flight transaction on rst mid-burst with no further AXI activity; the next row starts a fresh transaction.

Verification
REQ-030 SHALL cover: BASE_ADDR=0, row 3, data 0x8877665544332211, all readies high -> awaddr 0x018, beats 0x44332211 then 0x88776655 (wlast on 2nd), done 5 cycles after accept, error=0.
REQ-031 SHALL cover: awready held low 4 cycles -> awvalid/awaddr stable, wvalid stays 0 until AW handshake.
REQ-032 SHALL cover: wready toggling 0/1 per cycle -> each beat held until handshaken, exactly 2 beats, no duplicate.
REQ-033 SHALL cover: bresp=2'b10 (SLVERR) -> error=1 with done; next accepted row with OKAY -> error cleared at accept and 0 at done.
REQ-034 SHALL cover: rst asserted during DATA beat 1 -> all AXI valids drop in same cycle, busy=0; subsequent row 7 with BASE_ADDR=12'hFF8 -> awaddr 0x030 (wrap).
REQ-035 SHALL cover: in_valid held high through a transaction -> second row accepted only on the cycle after done, back-to-back transactions correct.
